// File: rtl/pe_gen_pkg.sv
// Shared definitions for the Generations PE: command encoding, reset rule
// masks (Life, B3/S23) and the two architecturally fixed state codes.
package pe_gen_pkg;

   typedef enum logic [2:0] {
      CMD_NOP     = 3'd0,
      CMD_PROCESS = 3'd1,
      CMD_WRITE   = 3'd2,
      CMD_RULE    = 3'd3,
      CMD_CLEAR   = 3'd4
   } cmd_t;

   localparam logic [8:0] LIFE_BIRTH   = 9'b000001000;
   localparam logic [8:0] LIFE_SURVIVE = 9'b000001100;

   localparam int STATE_DEAD  = 0;
   localparam int STATE_ALIVE = 1;

endpackage

// File: rtl/pe_gen_rule.sv
// Combinational Generations next-state function.
// Ports:
//   state   current cell state
//   count   live-neighbour count, 0..8
//   birth   bit k: dead cell with k live neighbours is born
//   survive bit k: live cell with k live neighbours survives
//   nxt     state after one PROCESS step
module pe_gen_rule
   import pe_gen_pkg::*;
#(
   parameter int N_STATES = 2,
   parameter int SB       = 1
) (
   input  logic [SB-1:0] state,
   input  logic [3:0]    count,
   input  logic [8:0]    birth,
   input  logic [8:0]    survive,
   output logic [SB-1:0] nxt
);

   int st;

   always_comb begin
      st  = int'(state);
      nxt = SB'(STATE_DEAD);
      if (st == STATE_DEAD) begin
         nxt = birth[count] ? SB'(STATE_ALIVE) : SB'(STATE_DEAD);
      end else if (st == STATE_ALIVE) begin
         // With only two states a dying live cell goes straight to dead.
         if (survive[count])
            nxt = SB'(STATE_ALIVE);
         else
            nxt = (N_STATES > 2) ? SB'(2) : SB'(STATE_DEAD);
      end else if (st < N_STATES - 1) begin
         nxt = state + SB'(1);
      end else begin
         // Last dying state and out-of-range written values both retire to dead.
         nxt = SB'(STATE_DEAD);
      end
   end

endmodule

// File: rtl/pe_gen.sv
// One tile of a Generations cellular automaton with run-time loadable
// birth/survive masks, refractory states, saturating age and a still-life flag.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rsel_i, csel_i      write select (both high = selected)
//   rsel_o, csel_o      read select (both high = selected)
//   cmd                 0 NOP, 1 PROCESS, 2 WRITE, 3 RULE, 4 CLEAR, 5-7 NOP
//   rule_birth/survive  masks captured on RULE
//   state_in            WRITE data
//   w_i..se_i           neighbour alive flags
//   status_out          1 iff state is alive
//   state_out, age_out  read-out, zero when not read-selected
//   active              the applied command changes the state this cycle
//   still               unchanged for STILL_GENS consecutive PROCESS steps
module pe_gen
   import pe_gen_pkg::*;
#(
   parameter int  N_STATES   = 2,
   parameter int  AGE_BITS   = 8,
   parameter int  STILL_GENS = 4,
   localparam int SB         = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rsel_i,
   input  logic                csel_i,
   input  logic                rsel_o,
   input  logic                csel_o,
   input  logic [2:0]          cmd,
   input  logic [8:0]          rule_birth,
   input  logic [8:0]          rule_survive,
   input  logic [SB-1:0]       state_in,
   input  logic                w_i,
   input  logic                e_i,
   input  logic                n_i,
   input  logic                s_i,
   input  logic                nw_i,
   input  logic                ne_i,
   input  logic                sw_i,
   input  logic                se_i,
   output logic                status_out,
   output logic [SB-1:0]       state_out,
   output logic [AGE_BITS-1:0] age_out,
   output logic                active,
   output logic                still
);

   localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};
   localparam logic [3:0]          SG      = 4'(STILL_GENS);

   logic [SB-1:0]       state, state_n, nxt;
   logic [AGE_BITS-1:0] age, age_n;
   logic [3:0]          scnt, scnt_n;
   logic [8:0]          birth, birth_n, survive, survive_n;
   logic [3:0]          count;
   logic                wsel;

   assign count = 4'(w_i) + 4'(e_i) + 4'(n_i) + 4'(s_i)
                + 4'(nw_i) + 4'(ne_i) + 4'(sw_i) + 4'(se_i);
   assign wsel  = rsel_i & csel_i;

   pe_gen_rule #(.N_STATES(N_STATES), .SB(SB)) u_rule (
      .state   (state),
      .count   (count),
      .birth   (birth),
      .survive (survive),
      .nxt     (nxt)
   );

   always_comb begin
      state_n   = state;
      age_n     = age;
      scnt_n    = scnt;
      birth_n   = birth;
      survive_n = survive;
      case (cmd_t'(cmd))
         CMD_PROCESS: begin
            state_n = nxt;
            if (nxt != state) begin
               age_n  = '0;
               scnt_n = '0;
            end else begin
               if (state == SB'(STATE_ALIVE) && age != AGE_MAX)
                  age_n = age + 1'b1;
               if (scnt < SG)
                  scnt_n = scnt + 1'b1;
            end
         end
         CMD_WRITE: begin
            if (wsel) begin
               state_n = state_in;
               age_n   = '0;
               scnt_n  = '0;
            end
         end
         CMD_RULE: begin
            birth_n   = rule_birth;
            survive_n = rule_survive;
         end
         CMD_CLEAR: begin
            state_n = '0;
            age_n   = '0;
            scnt_n  = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= '0;
         age     <= '0;
         scnt    <= '0;
         birth   <= LIFE_BIRTH;
         survive <= LIFE_SURVIVE;
      end else begin
         state   <= state_n;
         age     <= age_n;
         scnt    <= scnt_n;
         birth   <= birth_n;
         survive <= survive_n;
      end
   end

   assign active     = (state_n != state);
   assign still      = (scnt == SG);
   assign status_out = (state == SB'(STATE_ALIVE));
   assign state_out  = (rsel_o & csel_o) ? state : '0;
   assign age_out    = (rsel_o & csel_o) ? age   : '0;

endmodule

// File: tb/tb_pe_gen.sv
// Directed bench for pe_gen: dut_a is plain Life (N_STATES=2, AGE_BITS=8),
// dut_b has two dying states and a 3-bit age (N_STATES=4, AGE_BITS=3).
// Both share every control/neighbour input; each has its own write data.
module tb_pe_gen;

   logic       clk = 0;
   logic       rst;
   logic       rsel_i, csel_i, rsel_o, csel_o;
   logic [2:0] cmd;
   logic [8:0] birth, survive;
   logic [7:0] nb;
   logic [0:0] sin_a;
   logic [1:0] sin_b;

   logic       stat_a, act_a, still_a;
   logic [0:0] st_a;
   logic [7:0] age_a;
   logic       stat_b, act_b, still_b;
   logic [1:0] st_b;
   logic [2:0] age_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pe_gen #(.N_STATES(2), .AGE_BITS(8), .STILL_GENS(4)) dut_a (
      .clk(clk), .rst(rst), .rsel_i(rsel_i), .csel_i(csel_i),
      .rsel_o(rsel_o), .csel_o(csel_o), .cmd(cmd),
      .rule_birth(birth), .rule_survive(survive), .state_in(sin_a),
      .w_i(nb[0]), .e_i(nb[1]), .n_i(nb[2]), .s_i(nb[3]),
      .nw_i(nb[4]), .ne_i(nb[5]), .sw_i(nb[6]), .se_i(nb[7]),
      .status_out(stat_a), .state_out(st_a), .age_out(age_a),
      .active(act_a), .still(still_a)
   );

   pe_gen #(.N_STATES(4), .AGE_BITS(3), .STILL_GENS(4)) dut_b (
      .clk(clk), .rst(rst), .rsel_i(rsel_i), .csel_i(csel_i),
      .rsel_o(rsel_o), .csel_o(csel_o), .cmd(cmd),
      .rule_birth(birth), .rule_survive(survive), .state_in(sin_b),
      .w_i(nb[0]), .e_i(nb[1]), .n_i(nb[2]), .s_i(nb[3]),
      .nw_i(nb[4]), .ne_i(nb[5]), .sw_i(nb[6]), .se_i(nb[7]),
      .status_out(stat_b), .state_out(st_b), .age_out(age_b),
      .active(act_b), .still(still_b)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nb(input int n);
      nb = '0;
      for (int i = 0; i < n; i++) nb[i] = 1'b1;
   endtask

   task automatic do_cmd(input logic [2:0] c);
      cmd = c;
      tick();
      cmd = 3'd0;
   endtask

   task automatic test_reset();
      rst = 0; rsel_i = 0; csel_i = 0; rsel_o = 1; csel_o = 1;
      cmd = 0; birth = 0; survive = 0; nb = 0; sin_a = 0; sin_b = 0;
      #3;
      checks++;
      if (st_a !== 1'd0 || age_a !== 8'd0 || still_a !== 1'b0 || stat_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_a state=%0d age=%0d still=%0d status=%0d want 0 0 0 0",
                  st_a, age_a, still_a, stat_a);
      end
      checks++;
      if (st_b !== 2'd0 || age_b !== 3'd0 || still_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_b state=%0d age=%0d still=%0d want 0 0 0", st_b, age_b, still_b);
      end
      tick();
      rst = 1;
      tick();
   endtask

   task automatic test_life_birth();
      set_nb(3);
      cmd = 3'd1;
      #1;
      checks++;
      if (act_a !== 1'b1) begin
         errors++; $display("FAIL life_active got %0d want 1", act_a);
      end
      tick();
      cmd = 3'd0;
      checks++;
      if (st_a !== 1'd1 || stat_a !== 1'b1) begin
         errors++; $display("FAIL life_birth state=%0d status=%0d want 1 1", st_a, stat_a);
      end
      checks++;
      if (st_b !== 2'd1) begin
         errors++; $display("FAIL life_birth_b state=%0d want 1", st_b);
      end
   endtask

   task automatic test_highlife();
      birth = 9'h048; survive = 9'h00C;
      cmd = 3'd3;
      #1;
      checks++;
      if (act_a !== 1'b0) begin
         errors++; $display("FAIL rule_active got %0d want 0", act_a);
      end
      tick();
      cmd = 3'd0;
      checks++;
      if (st_a !== 1'd1) begin
         errors++; $display("FAIL rule_keeps_state got %0d want 1", st_a);
      end
      do_cmd(3'd4);
      checks++;
      if (st_a !== 1'd0 || st_b !== 2'd0) begin
         errors++; $display("FAIL clear a=%0d b=%0d want 0 0", st_a, st_b);
      end
      set_nb(6);
      do_cmd(3'd1);
      checks++;
      if (st_a !== 1'd1) begin
         errors++; $display("FAIL b36_six got %0d want 1", st_a);
      end
      do_cmd(3'd4);
      set_nb(5);
      do_cmd(3'd1);
      checks++;
      if (st_a !== 1'd0) begin
         errors++; $display("FAIL b36_five got %0d want 0", st_a);
      end
   endtask

   task automatic test_dying();
      logic [1:0] exp_b [4];
      exp_b[0] = 2'd2; exp_b[1] = 2'd3; exp_b[2] = 2'd0; exp_b[3] = 2'd0;
      rsel_i = 1; csel_i = 1; sin_a = 1'd1; sin_b = 2'd1;
      do_cmd(3'd2);
      rsel_i = 0; csel_i = 0;
      set_nb(1);
      for (int i = 0; i < 4; i++) begin
         do_cmd(3'd1);
         checks++;
         if (st_b !== exp_b[i] || stat_b !== 1'b0 || age_b !== 3'd0) begin
            errors++;
            $display("FAIL dying_step%0d state=%0d status=%0d age=%0d want %0d 0 0",
                     i, st_b, stat_b, age_b, exp_b[i]);
         end
      end
      checks++;
      if (st_a !== 1'd0) begin
         errors++; $display("FAIL two_state_death got %0d want 0", st_a);
      end
   endtask

   task automatic test_age();
      logic [2:0] ea;
      logic       es;
      rsel_i = 1; csel_i = 1; sin_a = 1'd1; sin_b = 2'd1;
      do_cmd(3'd2);
      rsel_i = 0; csel_i = 0;
      set_nb(2);
      for (int i = 1; i <= 10; i++) begin
         do_cmd(3'd1);
         ea = (i > 7) ? 3'd7 : 3'(i);
         es = (i >= 4);
         checks++;
         if (st_b !== 2'd1 || age_b !== ea || still_b !== es) begin
            errors++;
            $display("FAIL age_step%0d state=%0d age=%0d still=%0d want 1 %0d %0d",
                     i, st_b, age_b, still_b, ea, es);
         end
      end
      checks++;
      if (age_a !== 8'd10) begin
         errors++; $display("FAIL age_wide got %0d want 10", age_a);
      end
      rsel_i = 1; csel_i = 1;
      cmd = 3'd2;
      #1;
      checks++;
      if (act_b !== 1'b0) begin
         errors++; $display("FAIL write_same_active got %0d want 0", act_b);
      end
      tick();
      cmd = 3'd0; rsel_i = 0; csel_i = 0;
      checks++;
      if (st_b !== 2'd1 || age_b !== 3'd0 || still_b !== 1'b0) begin
         errors++;
         $display("FAIL write_resets_age state=%0d age=%0d still=%0d want 1 0 0",
                  st_b, age_b, still_b);
      end
   endtask

   task automatic test_select();
      rsel_i = 1; csel_i = 0; sin_a = 1'd0; sin_b = 2'd0;
      cmd = 3'd2;
      #1;
      checks++;
      if (act_b !== 1'b0) begin
         errors++; $display("FAIL unsel_write_active got %0d want 0", act_b);
      end
      tick();
      cmd = 3'd0; rsel_i = 0;
      checks++;
      if (st_b !== 2'd1) begin
         errors++; $display("FAIL unsel_write got %0d want 1", st_b);
      end
      set_nb(2);
      for (int i = 0; i < 4; i++) do_cmd(3'd1);
      rsel_o = 0;
      #1;
      checks++;
      if (st_b !== 2'd0 || age_b !== 3'd0 || st_a !== 1'd0 || age_a !== 8'd0) begin
         errors++;
         $display("FAIL read_unsel state=%0d age=%0d want 0 0", st_b, age_b);
      end
      rsel_o = 1;
      #1;
      checks++;
      if (st_b !== 2'd1 || age_b !== 3'd4 || still_b !== 1'b1) begin
         errors++;
         $display("FAIL read_sel state=%0d age=%0d still=%0d want 1 4 1", st_b, age_b, still_b);
      end
   endtask

   task automatic test_reset_mid();
      birth = 9'h004; survive = 9'h004;
      do_cmd(3'd3);
      do_cmd(3'd4);
      #2;
      rst = 0;
      #1;
      checks++;
      if (st_b !== 2'd0 || age_b !== 3'd0 || still_b !== 1'b0 || stat_b !== 1'b0) begin
         errors++;
         $display("FAIL async_reset state=%0d age=%0d still=%0d want 0 0 0", st_b, age_b, still_b);
      end
      #1;
      rst = 1;
      set_nb(3);
      do_cmd(3'd1);
      checks++;
      if (st_a !== 1'd1 || st_b !== 2'd1) begin
         errors++; $display("FAIL life_restored a=%0d b=%0d want 1 1", st_a, st_b);
      end
   endtask

   task automatic test_mid_reset_live();
      // Build a live, aged, still cell and reset it between edges.
      set_nb(2);
      for (int i = 0; i < 4; i++) do_cmd(3'd1);
      #2;
      rst = 0;
      #1;
      checks++;
      if (st_b !== 2'd0 || age_b !== 3'd0 || still_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_live state=%0d age=%0d still=%0d want 0 0 0", st_b, age_b, still_b);
      end
      #1;
      rst = 1;
   endtask

   initial begin
      test_reset();
      test_life_birth();
      test_highlife();
      test_dying();
      test_age();
      test_select();
      test_reset_mid();
      test_mid_reset_live();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
